// File: rtl/tx_pause_frame_gen_pkg.sv
// MAC-control constants and state encoding shared by the tx PAUSE
// generator and the rx PAUSE decoder.
package tx_pause_frame_gen_pkg;

    localparam logic [47:0] PAUSE_DA     = 48'h0180C2000001;
    localparam logic [15:0] ETH_TYPE     = 16'h8808;
    localparam logic [15:0] OPCODE       = 16'h0001;
    localparam int          QUANTA_SHIFT = 3;
    localparam int          FRAME_BEATS  = 8;
    localparam logic [2:0]  LAST_BEAT    = 3'(FRAME_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        SEND
    } pause_state_e;

    // Wire-order vector (octet 0 in the MSBs) to bus order (octet 0 in the LSBs).
    function automatic logic [63:0] wire_to_bus(input logic [63:0] w);
        logic [63:0] b;
        for (int n = 0; n < 8; n++) begin
            b[8*n +: 8] = w[63-8*n -: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/pause_beat_mux.sv
// Combinational byte map of a PAUSE frame: beat index, station address
// and quanta to one 64-bit client-transmit beat.
module pause_beat_mux
    import tx_pause_frame_gen_pkg::*;
(
    input  logic        active_i,
    input  logic [2:0]  cnt_i,
    input  logic [47:0] mac_i,
    input  logic [15:0] quanta_i,
    output logic [63:0] data_o,
    output logic [7:0]  ben_o,
    output logic        sof_o,
    output logic        eof_o
);

    logic [63:0] wire_w;

    always_comb begin
        wire_w = '0;
        unique case (cnt_i)
            3'd0:    wire_w = {PAUSE_DA, mac_i[47:32]};
            3'd1:    wire_w = {mac_i[31:0], ETH_TYPE, OPCODE};
            3'd2:    wire_w = {quanta_i, 48'h0};
            default: wire_w = '0;
        endcase
    end

    always_comb begin
        data_o = '0;
        ben_o  = '0;
        sof_o  = 1'b0;
        eof_o  = 1'b0;
        if (active_i) begin
            data_o = wire_to_bus(wire_w);
            ben_o  = (cnt_i == LAST_BEAT) ? 8'h0F : 8'hFF;
            sof_o  = (cnt_i == 3'd0);
            eof_o  = (cnt_i == LAST_BEAT);
        end
    end

endmodule

// File: rtl/tx_pause_frame_gen.sv
// 802.3x PAUSE frame generator on the 64-bit client transmit path.
// Build option PAUSE_REFRESH_EN adds self-refresh at half the pause time.
module tx_pause_frame_gen
    import tx_pause_frame_gen_pkg::*;
(
    input  logic        txclk,
    input  logic        reset,
    input  logic [47:0] MAC_Addr,
    input  logic        pause_req,
    input  logic [15:0] pause_quanta,
`ifdef PAUSE_REFRESH_EN
    input  logic        refresh_en,
`endif
    output logic        pause_busy,
    output logic        pause_sent,
    output logic        tx_req,
    input  logic        tx_gnt,
    input  logic        tx_ready,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_ben,
    output logic        tx_sof,
    output logic        tx_eof
);

    pause_state_e state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [15:0]  quanta_q, quanta_d;
    logic [15:0]  shadow_q, shadow_d;
    logic         pend_q, pend_d;
    logic         gap_q, gap_d;
    logic         sent_q, sent_d;

    logic         req;
    logic         self_req;
    logic [15:0]  req_quanta;
    logic         accept;
    logic         last;

    assign accept = (state_q == SEND) && tx_ready;
    assign last   = accept && (cnt_q == LAST_BEAT);
    assign req    = pause_req || self_req;

`ifdef PAUSE_REFRESH_EN
    logic [18:0] ref_q, ref_d;
    logic [15:0] rq_q, rq_d;

    assign self_req   = refresh_en && (ref_q == 19'd1);
    assign req_quanta = pause_req ? pause_quanta : rq_q;

    // Reload at half the pause time of the frame just sent; Q=0 clears.
    always_comb begin
        ref_d = ref_q;
        rq_d  = rq_q;
        if (!refresh_en) begin
            ref_d = '0;
        end else if (last) begin
            ref_d = {3'b000, quanta_q} << (QUANTA_SHIFT - 1);
            rq_d  = quanta_q;
        end else if (ref_q != '0) begin
            ref_d = ref_q - 19'd1;
        end
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            ref_q <= '0;
            rq_q  <= '0;
        end else begin
            ref_q <= ref_d;
            rq_q  <= rq_d;
        end
    end
`else
    assign self_req   = 1'b0;
    assign req_quanta = pause_quanta;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quanta_d = quanta_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        gap_d    = 1'b0;
        sent_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    quanta_d = req_quanta;
                    state_d  = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (req) quanta_d = req_quanta;
                // gap_q keeps tx_req low for a cycle between back-to-back frames
                if (tx_gnt && !gap_q) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (req) begin
                    shadow_d = req_quanta;
                    pend_d   = 1'b1;
                end
                if (accept) cnt_d = cnt_q + 3'd1;
                if (last) begin
                    sent_d = 1'b1;
                    cnt_d  = '0;
                    if (req || pend_q) begin
                        quanta_d = req ? req_quanta : shadow_q;
                        pend_d   = 1'b0;
                        gap_d    = 1'b1;
                        state_d  = WAIT_GNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quanta_q <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            gap_q    <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quanta_q <= quanta_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            gap_q    <= gap_d;
            sent_q   <= sent_d;
        end
    end

    assign tx_req     = ((state_q == WAIT_GNT) && !gap_q) || (state_q == SEND);
    assign pause_busy = (state_q != IDLE) || pend_q;
    assign pause_sent = sent_q;

    pause_beat_mux u_mux (
        .active_i (state_q == SEND),
        .cnt_i    (cnt_q),
        .mac_i    (MAC_Addr),
        .quanta_i (quanta_q),
        .data_o   (tx_data),
        .ben_o    (tx_ben),
        .sof_o    (tx_sof),
        .eof_o    (tx_eof)
    );

endmodule

// File: tb/tb_tx_pause_frame_gen.sv
// Self-checking bench for tx_pause_frame_gen: accepted beats are reassembled
// into 60-byte frames and compared with frames built from the byte layout.
module tb_tx_pause_frame_gen;

    logic        txclk = 1'b0;
    logic        reset = 1'b0;
    logic [47:0] MAC_Addr = '0;
    logic        pause_req = 1'b0;
    logic [15:0] pause_quanta = '0;
    logic        pause_busy;
    logic        pause_sent;
    logic        tx_req;
    logic        tx_gnt = 1'b0;
    logic        tx_ready = 1'b0;
    logic [63:0] tx_data;
    logic [7:0]  tx_ben;
    logic        tx_sof;
    logic        tx_eof;
`ifdef PAUSE_REFRESH_EN
    logic        refresh_en = 1'b0;
`endif

    int checks = 0;
    int passed = 0;

    tx_pause_frame_gen dut (
        .txclk        (txclk),
        .reset        (reset),
        .MAC_Addr     (MAC_Addr),
        .pause_req    (pause_req),
        .pause_quanta (pause_quanta),
`ifdef PAUSE_REFRESH_EN
        .refresh_en   (refresh_en),
`endif
        .pause_busy   (pause_busy),
        .pause_sent   (pause_sent),
        .tx_req       (tx_req),
        .tx_gnt       (tx_gnt),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_ben       (tx_ben),
        .tx_sof       (tx_sof),
        .tx_eof       (tx_eof)
    );

    always #5 txclk = ~txclk;

    // Reference frame: wire octet i lands at bits [8i+7:8i].
    function automatic logic [511:0] exp_frame(input logic [47:0] mac,
                                               input logic [15:0] q);
        logic [7:0]   b [64];
        logic [511:0] f;
        foreach (b[i]) b[i] = 8'h00;
        b[0] = 8'h01; b[1] = 8'h80; b[2] = 8'hC2;
        b[3] = 8'h00; b[4] = 8'h00; b[5] = 8'h01;
        for (int i = 0; i < 6; i++) b[6+i] = mac[47-8*i -: 8];
        b[12] = 8'h88; b[13] = 8'h08; b[14] = 8'h00; b[15] = 8'h01;
        b[16] = q[15:8]; b[17] = q[7:0];
        f = '0;
        for (int i = 0; i < 64; i++) f[8*i +: 8] = b[i];
        return f;
    endfunction

    logic [511:0] mon_cur;
    int           mon_idx;
    bit           mon_ok;
    int           accepts = 0;
    logic [511:0] rx_frame [$];
    bit           rx_ok [$];

    always @(negedge txclk) begin
        if (!reset) begin
            mon_idx = 0;
            mon_cur = '0;
            mon_ok  = 1'b1;
        end else if (tx_ben != 8'h00 && tx_ready) begin
            accepts++;
            if (tx_sof != (mon_idx == 0)) mon_ok = 1'b0;
            if (tx_ben != ((mon_idx == 7) ? 8'h0F : 8'hFF)) mon_ok = 1'b0;
            if (mon_idx < 8) begin
                for (int b = 0; b < 8; b++)
                    if (tx_ben[b]) mon_cur[mon_idx*64 + b*8 +: 8] = tx_data[b*8 +: 8];
            end
            if (tx_eof) begin
                if (mon_idx != 7) mon_ok = 1'b0;
                rx_frame.push_back(mon_cur);
                rx_ok.push_back(mon_ok);
                mon_idx = 0;
                mon_cur = '0;
                mon_ok  = 1'b1;
            end else begin
                mon_idx++;
            end
        end
    end

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic clear_rx();
        rx_frame.delete();
        rx_ok.delete();
    endtask

    task automatic wait_sent(input int budget, input bit rand_ready, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pause_sent) begin
                ok = 1'b1;
                break;
            end
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [79:0] outs;
        reset = 1'b0;
        repeat (3) tick();
        outs = {tx_data, tx_ben, tx_req, tx_sof, tx_eof, pause_busy, pause_sent, 3'b000};
        checks++;
        if (outs !== 80'h0) $display("FAIL reset_outputs got=%h want=0", outs);
        else passed++;
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({pause_busy, tx_req, tx_ben} !== 10'h0)
            $display("FAIL reset_release_idle got busy=%b req=%b ben=%h want 0",
                     pause_busy, tx_req, tx_ben);
        else passed++;
    endtask

    task automatic test_basic();
        logic [511:0] f;
        logic [74:0]  got, want;
        clear_rx();
        MAC_Addr = 48'h001122334455;
        tx_gnt   = 1'b1;
        tx_ready = 1'b1;
        f = exp_frame(MAC_Addr, 16'h1234);
        pause_quanta = 16'h1234;
        pause_req    = 1'b1;
        tick();
        pause_req    = 1'b0;
        pause_quanta = 16'hDEAD;
        checks++;
        if (tx_req !== 1'b1 || tx_ben !== 8'h00 || pause_busy !== 1'b1)
            $display("FAIL basic_req_latency got req=%b ben=%h busy=%b want 1/00/1",
                     tx_req, tx_ben, pause_busy);
        else passed++;
        tick();
        checks++;
        if (tx_data !== 64'h1100010000C28001)
            $display("FAIL basic_beat0_const got=%h want=1100010000c28001", tx_data);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            got  = {tx_data, tx_ben, tx_sof, tx_eof, pause_sent};
            want = {f[64*k +: 64], (k == 7) ? 8'h0F : 8'hFF, k == 0, k == 7, 1'b0};
            checks++;
            if (got !== want) $display("FAIL basic_beat%0d got=%h want=%h", k, got, want);
            else passed++;
            tick();
        end
        checks++;
        if ({pause_sent, tx_req, tx_ben} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL basic_sent_pulse got sent=%b req=%b ben=%h want 1/0/00",
                     pause_sent, tx_req, tx_ben);
        else passed++;
        tick();
        checks++;
        if (pause_sent !== 1'b0 || pause_busy !== 1'b0)
            $display("FAIL basic_after_sent got sent=%b busy=%b want 0/0",
                     pause_sent, pause_busy);
        else passed++;
        checks++;
        if (rx_frame.size() != 1 || rx_frame[0] !== f || !rx_ok[0])
            $display("FAIL basic_frame got n=%0d want n=1 with matching bytes",
                     rx_frame.size());
        else passed++;
    endtask

    task automatic test_gnt_wait();
        logic [15:0]  q;
        logic [511:0] f;
        bit           ok;
        clear_rx();
        q = 16'($urandom);
        f = exp_frame(MAC_Addr, q);
        tx_gnt = 1'b0;
        pause_quanta = q;
        pause_req    = 1'b1;
        tick();
        pause_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (tx_req !== 1'b1 || tx_ben !== 8'h00)
                $display("FAIL gnt_wait_c%0d got req=%b ben=%h want 1/00", i, tx_req, tx_ben);
            else passed++;
            tick();
        end
        tx_gnt = 1'b1;
        tick();
        checks++;
        if (tx_sof !== 1'b1 || tx_data !== f[63:0])
            $display("FAIL gnt_wait_beat0 got sof=%b data=%h want 1/%h", tx_sof, tx_data, f[63:0]);
        else passed++;
        wait_sent(100, 1'b0, ok);
        checks++;
        if (!ok || rx_frame.size() != 1 || rx_frame[0] !== f || !rx_ok[0])
            $display("FAIL gnt_wait_frame got sent=%b n=%0d want 1/1", ok, rx_frame.size());
        else passed++;
        tick();
    endtask

    task automatic test_ready_toggle();
        logic [15:0]  q;
        logic [511:0] f;
        logic [74:0]  prev, cur;
        bit           prev_v, prev_r, r, done;
        int           a0, holds;
        clear_rx();
        q = 16'($urandom);
        f = exp_frame(MAC_Addr, q);
        tx_gnt = 1'b1;
        tx_ready = 1'b1;
        pause_quanta = q;
        pause_req = 1'b1;
        tick();
        pause_req = 1'b0;
        tick();
        a0 = accepts;
        r = 1'b1;
        prev_v = 1'b0;
        prev_r = 1'b1;
        prev = '0;
        done = 1'b0;
        holds = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            tx_ready = r;
            cur = {tx_data, tx_ben, tx_sof, tx_eof, 1'b0};
            if (prev_v && !prev_r) begin
                holds++;
                checks++;
                if (cur !== prev) $display("FAIL ready_hold_c%0d got=%h want=%h", c, cur, prev);
                else passed++;
            end
            prev   = cur;
            prev_v = (tx_ben != 8'h00);
            prev_r = r;
            r = ~r;
            tick();
            if (pause_sent) done = 1'b1;
        end
        tx_ready = 1'b1;
        checks++;
        if (!done || accepts - a0 != 8 || holds < 7)
            $display("FAIL ready_accepts got done=%b accepts=%0d holds=%0d want 1/8/>=7",
                     done, accepts - a0, holds);
        else passed++;
        checks++;
        if (rx_frame.size() != 1 || rx_frame[0] !== f || !rx_ok[0])
            $display("FAIL ready_frame got n=%0d want 1 matching", rx_frame.size());
        else passed++;
        tick();
    endtask

    task automatic test_pending();
        logic [15:0] q0, pend;
        logic [15:0] exp_q [$];
        bit          ok;
        clear_rx();
        q0 = 16'($urandom) | 16'h0100;
        exp_q.push_back(q0);
        tx_gnt = 1'b1;
        tx_ready = 1'b1;
        pause_quanta = q0;
        pause_req = 1'b1;
        tick();
        pause_req = 1'b0;
        tick();
        repeat (3) tick();
        pause_req = 1'b1;
        pause_quanta = 16'h0005;
        pend = 16'h0005;
        tick();
        pause_quanta = 16'h0000;
        pend = 16'h0000;
        tick();
        pause_req = 1'b0;
        pause_quanta = 16'h7777;
        exp_q.push_back(pend);
        wait_sent(50, 1'b0, ok);
        checks++;
        if (!ok || tx_req !== 1'b0 || pause_busy !== 1'b1)
            $display("FAIL pend_gap got sent=%b req=%b busy=%b want 1/0/1",
                     ok, tx_req, pause_busy);
        else passed++;
        tick();
        wait_sent(50, 1'b0, ok);
        repeat (40) tick();
        checks++;
        if (!ok || rx_frame.size() != 2 || pause_busy !== 1'b0)
            $display("FAIL pend_count got sent=%b n=%0d busy=%b want 1/2/0",
                     ok, rx_frame.size(), pause_busy);
        else passed++;
        for (int i = 0; i < 2 && i < rx_frame.size(); i++) begin
            checks++;
            if (rx_frame[i] !== exp_frame(MAC_Addr, exp_q[i]) || !rx_ok[i])
                $display("FAIL pend_frame%0d got q=%h want q=%h", i,
                         {rx_frame[i][135:128], rx_frame[i][143:136]}, exp_q[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [79:0] outs;
        bit          seen;
        clear_rx();
        tx_gnt = 1'b1;
        tx_ready = 1'b1;
        pause_quanta = 16'h4242;
        pause_req = 1'b1;
        tick();
        pause_req = 1'b0;
        tick();
        repeat (4) tick();
        reset = 1'b0;
        #1;
        outs = {tx_data, tx_ben, tx_req, tx_sof, tx_eof, pause_busy, pause_sent, 3'b000};
        checks++;
        if (outs !== 80'h0) $display("FAIL midreset_outputs got=%h want=0", outs);
        else passed++;
        repeat (2) tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx_req || tx_ben != 8'h00 || pause_sent || pause_busy) seen = 1'b1;
        end
        checks++;
        if (seen || rx_frame.size() != 0)
            $display("FAIL midreset_no_resume got activity=%b frames=%0d want 0/0",
                     seen, rx_frame.size());
        else passed++;
    endtask

    task automatic test_random();
        logic [63:0]  r64;
        logic [15:0]  q;
        logic [511:0] f;
        bit           ok;
        int           gd;
        for (int i = 0; i < 8; i++) begin
            clear_rx();
            r64 = {$urandom, $urandom};
            MAC_Addr = r64[47:0];
            q = (i == 2) ? 16'h0000 : 16'($urandom);
            f = exp_frame(MAC_Addr, q);
            gd = $urandom_range(0, 3);
            tx_gnt = (gd == 0);
            pause_quanta = q;
            pause_req = 1'b1;
            tick();
            pause_req = 1'b0;
            pause_quanta = 16'($urandom);
            for (int g = 0; g < gd; g++) begin
                tx_ready = ($urandom_range(0, 1) != 0);
                tick();
            end
            tx_gnt = 1'b1;
            wait_sent(200, 1'b1, ok);
            checks++;
            if (!ok || rx_frame.size() != 1 || rx_frame[0] !== f || !rx_ok[0])
                $display("FAIL rand_frame%0d got sent=%b n=%0d want 1/1 q=%h", i,
                         ok, rx_frame.size(), q);
            else passed++;
            tx_gnt = 1'b0;
            repeat (2) tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_wait();
        test_ready_toggle();
        test_pending();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
